// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xor_acc.sv
// Registered two-operand XOR with valid/ready handshake: pairwise XOR per beat,
// or XOR-accumulate over FRAME_LEN beats, plus a reduction parity of the result.
module gf180mcu_fd_sc_mcu9t5v0__xor_acc #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic             MODE,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Z,
    output logic             PAR,
    output logic             Z_VALID,
    input  logic             Z_READY,
    output logic             BUSY,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    logic [WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             par_q, par_d;
    logic             zv_q, zv_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             eff_mode;
    logic             last_beat;
    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] sum;

    // Supply pins carry no function; fold them into a sink net.
    wire unused_supply = VDD ^ VSS;

    // A frame's mode is frozen at its first beat; MODE only matters at a frame boundary.
    assign eff_mode  = (cnt_q == '0) ? MODE : mode_q;
    assign last_beat = ~eff_mode | (cnt_q == LAST_CNT);
    assign IN_READY  = RN & ~FLUSH & (~last_beat | ~zv_q | Z_READY);
    assign accept    = IN_VALID & IN_READY;
    assign pop       = zv_q & Z_READY;
    assign sum       = ((cnt_q == '0) ? '0 : acc_q) ^ A1 ^ A2;

    // NOTE: every next-state signal gets a hold default first so no latch is inferred.
    always_comb begin
        z_d    = z_q;
        par_d  = par_q;
        zv_d   = zv_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;

        if (pop) begin
            zv_d = 1'b0;
        end

        if (FLUSH) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            if (cnt_q == '0) begin
                mode_d = MODE;
            end
            if (last_beat) begin
                z_d   = sum;
                par_d = ^sum;
                zv_d  = 1'b1;
                cnt_d = '0;
                acc_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments; reset is synchronous and
    // clears the whole datapath, including the result register.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            z_q    <= '0;
            par_q  <= 1'b0;
            zv_q   <= 1'b0;
            acc_q  <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            z_q    <= z_d;
            par_q  <= par_d;
            zv_q   <= zv_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign Z       = z_q;
    assign PAR     = par_q;
    assign Z_VALID = zv_q;
    assign BUSY    = (cnt_q != '0);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__xor_acc.sv
// Directed bench: expected results queued at stimulus time, compared when the DUT pops them.
module tb_gf180mcu_fd_sc_mcu9t5v0__xor_acc;

    logic       clk = 1'b0;
    logic       rn;
    logic [7:0] a1, a2;
    logic       mode, flush, in_valid, z_ready;
    wire        in_ready;
    wire  [7:0] z;
    wire        par, z_valid, busy;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;

    typedef struct packed {
        logic [7:0] z;
        logic       par;
    } res_t;

    res_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__xor_acc #(.WIDTH(8), .FRAME_LEN(4)) dut (
        .CLK(clk), .RN(rn), .A1(a1), .A2(a2), .MODE(mode), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready), .Z(z), .PAR(par),
        .Z_VALID(z_valid), .Z_READY(z_ready), .BUSY(busy), .VDD(vdd), .VSS(vss)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] ez, input logic ep);
        res_t e;
        e.z   = ez;
        e.par = ep;
        sb.push_back(e);
    endtask

    // One clock: drive, check IN_READY and any pop, then advance to 1 time unit past the edge.
    task automatic cyc(input string tag, input logic v, input logic [7:0] x1, input logic [7:0] x2,
                       input logic m, input logic fl, input logic zr, input logic exp_rdy);
        res_t e;
        in_valid = v; a1 = x1; a2 = x2; mode = m; flush = fl; z_ready = zr;
        #1;
        check({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
        if (z_valid === 1'b1 && z_ready) begin
            if (sb.size() == 0) begin
                check({tag, " unexpected_pop"}, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({tag, " z"}, {24'd0, z}, {24'd0, e.z});
                check({tag, " par"}, {31'd0, par}, {31'd0, e.par});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rn = 1'b0; in_valid = 1'b1; a1 = 8'h0; a2 = 8'h0; mode = 1'b0; flush = 1'b0; z_ready = 1'b0;

        // Reset with IN_VALID asserted
        cyc("rst0", 1, 8'h12, 8'h34, 0, 0, 0, 0);
        cyc("rst1", 1, 8'h12, 8'h34, 0, 0, 0, 0);
        check("rst z", {24'd0, z}, 32'h00);
        check("rst par", {31'd0, par}, 32'd0);
        check("rst z_valid", {31'd0, z_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        rn = 1'b1;
        cyc("idle", 0, 8'h00, 8'h00, 0, 0, 1, 1);

        // Pairwise stream
        push(8'hFF, 1'b0);
        cyc("pw1", 1, 8'hF0, 8'h0F, 0, 0, 1, 1);
        check("pw1 z_valid", {31'd0, z_valid}, 32'd1);
        push(8'h00, 1'b0);
        cyc("pw2", 1, 8'hAA, 8'hAA, 0, 0, 1, 1);
        check("pw2 z_valid", {31'd0, z_valid}, 32'd1);
        push(8'h81, 1'b0);
        cyc("pw3", 1, 8'h81, 8'h00, 0, 0, 1, 1);
        check("pw3 z_valid", {31'd0, z_valid}, 32'd1);
        cyc("pw_drain", 0, 8'h00, 8'h00, 0, 0, 1, 1);
        check("pw_drain z_valid", {31'd0, z_valid}, 32'd0);

        // Accumulate frame
        cyc("acc1", 1, 8'h01, 8'h00, 1, 0, 1, 1);
        check("acc1 busy", {31'd0, busy}, 32'd1);
        check("acc1 z_valid", {31'd0, z_valid}, 32'd0);
        cyc("acc2", 1, 8'h02, 8'h00, 1, 0, 1, 1);
        cyc("acc3", 1, 8'h04, 8'h00, 1, 0, 1, 1);
        check("acc3 z_valid", {31'd0, z_valid}, 32'd0);
        push(8'h87, 1'b0);
        cyc("acc4", 1, 8'h80, 8'h00, 1, 0, 1, 1);
        check("acc4 z_valid", {31'd0, z_valid}, 32'd1);
        check("acc4 busy", {31'd0, busy}, 32'd0);
        check("acc4 z", {24'd0, z}, 32'h87);

        // Backpressure: non-last beats flow, last beat stalls until the slot drains
        cyc("bp1", 1, 8'h10, 8'h00, 1, 0, 0, 1);
        cyc("bp2", 1, 8'h20, 8'h00, 1, 0, 0, 1);
        cyc("bp3", 1, 8'h40, 8'h00, 1, 0, 0, 1);
        cyc("bp4_stall", 1, 8'h08, 8'h00, 1, 0, 0, 0);
        check("bp4_stall z", {24'd0, z}, 32'h87);
        check("bp4_stall z_valid", {31'd0, z_valid}, 32'd1);
        check("bp4_stall busy", {31'd0, busy}, 32'd1);
        push(8'h78, 1'b0);
        cyc("bp4_go", 1, 8'h08, 8'h00, 1, 0, 1, 1);
        check("bp4_go z_valid", {31'd0, z_valid}, 32'd1);
        check("bp4_go busy", {31'd0, busy}, 32'd0);
        cyc("bp_drain", 0, 8'h00, 8'h00, 1, 0, 1, 1);
        check("bp_drain z_valid", {31'd0, z_valid}, 32'd0);

        // Flush a partial frame, then a pairwise beat
        cyc("fl1", 1, 8'h11, 8'h00, 1, 0, 1, 1);
        cyc("fl2", 1, 8'h22, 8'h00, 1, 0, 1, 1);
        check("fl2 busy", {31'd0, busy}, 32'd1);
        cyc("fl_flush", 1, 8'h33, 8'h00, 1, 1, 1, 0);
        check("fl_flush busy", {31'd0, busy}, 32'd0);
        check("fl_flush z_valid", {31'd0, z_valid}, 32'd0);
        push(8'h3F, 1'b0);
        cyc("fl_pw", 1, 8'h33, 8'h0C, 0, 0, 1, 1);
        check("fl_pw z_valid", {31'd0, z_valid}, 32'd1);
        cyc("fl_drain", 0, 8'h00, 8'h00, 0, 0, 1, 1);

        // MODE toggled mid-frame is ignored until the frame completes
        cyc("mt1", 1, 8'h01, 8'h02, 1, 0, 1, 1);
        check("mt1 z_valid", {31'd0, z_valid}, 32'd0);
        cyc("mt2", 1, 8'h04, 8'h00, 0, 0, 1, 1);
        check("mt2 z_valid", {31'd0, z_valid}, 32'd0);
        cyc("mt3", 1, 8'h10, 8'h20, 0, 0, 1, 1);
        check("mt3 z_valid", {31'd0, z_valid}, 32'd0);
        check("mt3 busy", {31'd0, busy}, 32'd1);
        push(8'hF7, 1'b1);
        cyc("mt4", 1, 8'h40, 8'h80, 0, 0, 1, 1);
        check("mt4 z_valid", {31'd0, z_valid}, 32'd1);
        check("mt4 busy", {31'd0, busy}, 32'd0);
        cyc("mt_drain", 0, 8'h00, 8'h00, 0, 0, 1, 1);

        // Reset mid-frame discards the partial frame
        cyc("mr1", 1, 8'h55, 8'h00, 1, 0, 1, 1);
        check("mr1 busy", {31'd0, busy}, 32'd1);
        rn = 1'b0;
        cyc("mr_rst", 1, 8'h66, 8'h00, 1, 0, 1, 0);
        check("mr_rst busy", {31'd0, busy}, 32'd0);
        check("mr_rst z_valid", {31'd0, z_valid}, 32'd0);
        rn = 1'b1;
        cyc("mr_idle", 0, 8'h00, 8'h00, 0, 0, 1, 1);

        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__xor_acc.md
Name:
gf180mcu_fd_sc_mcu9t5v0__xor_acc

Overview:
- Parametrised, registered successor to the two-input XOR cell: a WIDTH-bit two-operand XOR datapath with a valid/ready handshake and a one-entry output register.
- Two modes:
  - Pairwise: Z = A1^A2 per beat.
  - Frame-accumulate: Z = XOR of (A1^A2) over FRAME_LEN beats.
- Also produces a reduction parity bit of Z.
- Used as a parity/checksum primitive in streaming paths built from the 9-track 5V cell set.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- FRAME_LEN, 4, beats per frame in accumulate mode (>=1; FRAME_LEN=1 behaves identically to pairwise).
- CW, $clog2(FRAME_LEN) (min 1), beat-counter width; derived, not overridden.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  reset. Synchronous, active-low, sampled on the CLK rising edge.
- A1  input  WIDTH  operand 1.
- A2  input  WIDTH  operand 2.
- MODE  input  1  0 = pairwise, 1 = frame-accumulate.
- FLUSH  input  1  synchronous discard of a partial frame.
- IN_VALID  input  1  operands valid.
- IN_READY  output  1  block can accept operands this cycle.
- Z  output  WIDTH  registered result.
- PAR  output  1  registered ^Z.
- Z_VALID  output  1  Z/PAR hold a result.
- Z_READY  input  1  downstream consumes the result.
- BUSY  output  1  partial frame in progress (cnt != 0).
- VDD  inout  1  supply; no functional effect.
- VSS  inout  1  ground; no functional effect.

Behaviour:
- Reset: RN=0 at a CLK edge clears Z=0, PAR=0, Z_VALID=0, acc=0, cnt=0, mode_q=0.
  - IN_READY is combinationally forced 0 while RN=0.
  - Reset mid-frame discards the partial frame and any unconsumed result.
- Handshakes:
  - accept = IN_VALID & IN_READY.
  - pop = Z_VALID & Z_READY.
- Effective mode: eff = (cnt==0) ? MODE : mode_q. mode_q is latched on the first accepted beat of a frame. MODE changes mid-frame are ignored until cnt returns to 0.
- last = (eff==0) | (cnt==FRAME_LEN-1).
- IN_READY = RN & ~FLUSH & (~last | ~Z_VALID | Z_READY).
  - Non-last accumulate beats never stall on a full output slot.
- Pairwise (eff=0), on accept:
  - Z <= A1^A2; PAR <= ^(A1^A2); Z_VALID <= 1.
  - Latency 1 cycle. Throughput 1 per cycle when Z_READY is held 1.
- Accumulate (eff=1), on accept:
  - s = (cnt==0 ? 0 : acc) ^ A1 ^ A2.
  - Not last: acc <= s; cnt <= cnt+1.
  - Last: Z <= s; PAR <= ^s; Z_VALID <= 1; cnt <= 0; acc <= 0.
  - Result appears 1 cycle after the last beat is accepted.
- Output slot:
  - pop without load: Z_VALID <= 0; Z/PAR hold their last values.
  - pop and load in the same cycle: Z_VALID stays 1 with the new data.
  - Z_VALID=1 and Z_READY=0: Z, PAR and Z_VALID stay stable.
- FLUSH=1 (RN=1): cnt <= 0, acc <= 0; IN_READY=0, so no beat is accepted that cycle.
  - The output slot is unaffected (a pending result is kept and can pop the same cycle).
  - FLUSH with cnt==0 is a no-op.
- Priority: RN=0 > FLUSH > accept.
- BUSY = (cnt != 0), registered state, combinational decode.
- Counter never exceeds FRAME_LEN-1 and wraps to 0 only on the last beat or a flush.

Test Plan:
- Reset/idle: RN=0 for 2 cycles with IN_VALID=1 -> IN_READY=0, Z=0x00, PAR=0, Z_VALID=0, BUSY=0. After RN=1 -> IN_READY=1.
- Pairwise stream: MODE=0, Z_READY=1; beats (A1,A2) = (0xF0,0x0F), (0xAA,0xAA), (0x81,0x00) -> next cycles Z = 0xFF/PAR=0, 0x00/PAR=0, 0x81/PAR=0, Z_VALID=1 each cycle.
- Accumulate frame: MODE=1, FRAME_LEN=4; A1^A2 = 0x01, 0x02, 0x04, 0x80 -> BUSY=1 after beat 1. Z=0x87, PAR=0, Z_VALID=1 one cycle after beat 4; BUSY=0.
- Backpressure: Z_READY=0 with a result held -> accumulate beats 1-3 of the next frame are accepted, beat 4 sees IN_READY=0 and Z stays 0x87. Raise Z_READY -> pop, and beat 4 is loaded the same cycle.
- Flush and mode change: MODE=1; 2 beats (0x11,0x00), (0x22,0x00); FLUSH for 1 cycle -> BUSY=0, no output. Then MODE=0 with (0x33,0x0C) -> Z=0x3F, PAR=0.
- Mid-frame mode toggle: MODE=1 on beat 1, MODE=0 on beats 2-4 -> beats 2-4 are still accumulated (mode_q=1), a single Z is emitted after beat 4, and no output appears after beats 1-3.
